// File: rtl/bitop_unit_arbiter_pkg.sv
// Purpose : shared op encodings for the bitop unit arbiter slice.
// Latency : n/a (types only).
// Backpressure: n/a.
package bitop_pkg;

   localparam int OP_W = 3;

   // Encoding is fixed; requesters drive these 3-bit codes directly.
   typedef enum logic [OP_W-1:0] {
      PASS = 3'd0,
      REV  = 3'd1,
      AND  = 3'd2,
      OR   = 3'd3,
      XOR  = 3'd4,
      IMPL = 3'd5,
      ADD  = 3'd6,
      SUB  = 3'd7
   } bitop_e;

endpackage

// File: rtl/bitop_unit_arbiter_if.sv
// Purpose : request/response bus between lane-op requesters and the shared unit.
// Latency : n/a (wiring only).
// Backpressure: req_* valid/ready per requester, rsp_* valid/ready single channel.
// Ports   : req_valid/req_ready/req_op/req_a/req_b packed per requester;
//           rsp_valid/rsp_ready/rsp_id/rsp_data tagged response.
interface bitop_unit_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*3-1:0]     req_op;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_data;

   // Requester/consumer side.
   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   // Shared unit side.
   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/bitop_unit_arbiter_alu.sv
// Purpose : combinational lane-wise / arithmetic op on two WIDTH-bit operands.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; sits between the S1 and S2 registers.
// Ports   : i_op op code, i_a/i_b operands, o_y result (carries/borrows dropped).
module bitop_alu
   import bitop_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  bitop_e           i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_y
);

   always_comb begin
      o_y = '0;
      case (i_op)
         PASS: o_y = i_a;
         REV: begin
            for (int i = 0; i < WIDTH; i++) o_y[i] = i_a[WIDTH-1-i];
         end
         AND:  o_y = i_a & i_b;
         OR:   o_y = i_a | i_b;
         XOR:  o_y = i_a ^ i_b;
         // Gated implication: a -> b per lane.
         IMPL: o_y = (i_a & i_b) | ~i_a;
         ADD:  o_y = i_a + i_b;
         SUB:  o_y = i_a - i_b;
         default: o_y = '0;
      endcase
   end

endmodule

// File: rtl/bitop_unit_arbiter.sv
// Purpose : round-robin shares one registered bitop ALU among NUM_REQ requesters.
// Latency : 2 cycles accept-to-rsp_valid; 1 op/cycle with rsp_ready high.
// Backpressure: rsp_ready low stalls S2, then S1, then all req_ready drop; rsp held stable.
// Ports   : clk, rst_n (async, active low), bus (slave modport), busy, done_cnt.
module bitop_unit_arbiter
   import bitop_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bitop_unit_arbiter_if.slave  bus,
   output logic                 busy,
   output logic [CNT_W-1:0]     done_cnt
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef struct packed {
      bitop_e           op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } op_t;

   logic [ID_W-1:0]  r_ptr;
   op_t              r_s1;
   logic [ID_W-1:0]  r_id1;
   logic             r_v1;
   logic [WIDTH-1:0] r_data2;
   logic [ID_W-1:0]  r_id2;
   logic             r_v2;
   logic [CNT_W-1:0] r_cnt;

   logic [ID_W-1:0]  w_cand;
   logic             w_found;
   logic             w_adv1;
   logic             w_adv2;
   logic             w_accept;
   op_t              w_sel;
   logic [WIDTH-1:0] w_y;

   // First valid requester after the last grant, wrapping around.
   always_comb begin
      w_cand  = r_ptr;
      w_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!w_found && bus.req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_cand  = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            w_found = 1'b1;
         end
      end
   end

   assign w_adv2   = !r_v2 || bus.rsp_ready;
   assign w_adv1   = !r_v1 || w_adv2;
   assign w_accept = w_adv1 && w_found;

   // Ready depends only on valids and pipe state, never on payload.
   always_comb begin
      bus.req_ready = '0;
      if (w_accept) bus.req_ready[w_cand] = 1'b1;
   end

   always_comb begin
      w_sel.op = bitop_e'(bus.req_op[int'(w_cand)*3 +: 3]);
      w_sel.a  = bus.req_a[int'(w_cand)*WIDTH +: WIDTH];
      w_sel.b  = bus.req_b[int'(w_cand)*WIDTH +: WIDTH];
   end

   bitop_alu #(.WIDTH(WIDTH)) u_alu (
      .i_op (r_s1.op),
      .i_a  (r_s1.a),
      .i_b  (r_s1.b),
      .o_y  (w_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= ID_W'(NUM_REQ - 1);
         r_s1    <= '0;
         r_id1   <= '0;
         r_v1    <= 1'b0;
         r_data2 <= '0;
         r_id2   <= '0;
         r_v2    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_ptr <= w_cand;
            r_s1  <= w_sel;
            r_id1 <= w_cand;
            r_v1  <= 1'b1;
         end else if (w_adv1) begin
            r_v1 <= 1'b0;
         end

         // S2 only reloads when a new op arrives, so data/id hold while stalled.
         if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r_data2 <= w_y;
               r_id2   <= r_id1;
            end
         end

         if (r_v2 && bus.rsp_ready) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bus.rsp_valid = r_v2;
   assign bus.rsp_id    = r_id2;
   assign bus.rsp_data  = r_data2;
   assign busy          = r_v1 | r_v2;
   assign done_cnt      = r_cnt;

endmodule

// File: tb/tb_bitop_unit_arbiter.sv
// Purpose : directed self-checking bench for bitop_unit_arbiter.
// Latency : n/a.
// Backpressure: exercised via rsp_ready stalls.
module tb_bitop_unit_arbiter;
   import bitop_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int CNT_W   = 4;

   logic             clk;
   logic             rst_n;
   logic             busy;
   logic [CNT_W-1:0] done_cnt;

   int n_assert;
   int n_fail;

   bitop_unit_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

   bitop_unit_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .done_cnt (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input bitop_e op, input logic [7:0] a, input logic [7:0] b);
      bus.req_op[3*i +: 3] = op;
      bus.req_a[8*i +: 8]  = a;
      bus.req_b[8*i +: 8]  = b;
   endtask

   logic [7:0] exp_dat [NUM_REQ];
   int         gq [10];
   int         e_ptr;
   int         g;
   int         accepts;

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n          = 1'b0;
      bus.req_valid  = '0;
      bus.req_op     = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.rsp_ready  = 1'b0;

      // ---- reset state
      #12;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done_cnt", 32'(done_cnt), 0);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- test 1: single XOR from requester 0
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      set_req(0, XOR, 8'hA5, 8'h0F);
      bus.req_valid = 4'b0001;
      #1 chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
      @(negedge clk);
      bus.req_valid = '0;
      #1 chk("t1_s1_no_rsp", 32'(bus.rsp_valid), 0);
      chk("t1_busy", 32'(busy), 1);
      @(negedge clk);
      chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("t1_rsp_id", 32'(bus.rsp_id), 0);
      chk("t1_rsp_data", 32'(bus.rsp_data), 32'hAA);
      @(negedge clk);
      chk("t1_rsp_gone", 32'(bus.rsp_valid), 0);
      chk("t1_done_cnt", 32'(done_cnt), 1);
      chk("t1_idle", 32'(busy), 0);
      e_ptr = 0;

      // ---- test 2: all four valid, round-robin order
      set_req(0, REV,  8'b0000_0001, 8'h00); exp_dat[0] = 8'h80;
      set_req(1, AND,  8'hF0, 8'h3C);        exp_dat[1] = 8'h30;
      set_req(2, OR,   8'hF0, 8'h0F);        exp_dat[2] = 8'hFF;
      set_req(3, PASS, 8'h5A, 8'hC3);        exp_dat[3] = 8'h5A;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
         #1;
         if (c < 8) begin
            g = (e_ptr + 1) % NUM_REQ;
            chk("t2_grant", 32'(bus.req_ready), 32'(1) << g);
            gq[c] = g;
            e_ptr = g;
         end else begin
            chk("t2_no_grant", 32'(bus.req_ready), 0);
         end
         if (c >= 2) begin
            chk("t2_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("t2_rsp_id", 32'(bus.rsp_id), 32'(gq[c-2]));
            chk("t2_rsp_data", 32'(bus.rsp_data), 32'(exp_dat[gq[c-2]]));
         end else begin
            chk("t2_rsp_early", 32'(bus.rsp_valid), 0);
         end
      end
      @(negedge clk);
      chk("t2_drained", 32'(bus.rsp_valid), 0);
      chk("t2_done_cnt", 32'(done_cnt), 9);

      // ---- test 3: rsp_ready low with all valid
      bus.rsp_ready = 1'b0;
      accepts = 0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         bus.req_valid = 4'b1111;
         #1;
         if (bus.req_ready != 0) accepts++;
         chk("t3_ready", 32'(bus.req_ready), (c == 0) ? 32'h2 : (c == 1) ? 32'h4 : 32'h0);
         if (c >= 2) begin
            chk("t3_hold_valid", 32'(bus.rsp_valid), 1);
            chk("t3_hold_id", 32'(bus.rsp_id), 1);
            chk("t3_hold_data", 32'(bus.rsp_data), 32'(exp_dat[1]));
         end
      end
      chk("t3_accepts", 32'(accepts), 2);
      @(negedge clk);
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      #1 chk("t3_rel_id1", 32'(bus.rsp_id), 1);
      chk("t3_rel_v1", 32'(bus.rsp_valid), 1);
      @(negedge clk);
      chk("t3_rel_v2", 32'(bus.rsp_valid), 1);
      chk("t3_rel_id2", 32'(bus.rsp_id), 2);
      chk("t3_rel_data2", 32'(bus.rsp_data), 32'(exp_dat[2]));
      @(negedge clk);
      chk("t3_no_dup", 32'(bus.rsp_valid), 0);
      chk("t3_done_cnt", 32'(done_cnt), 11);

      // ---- test 4: requester 0 streaming ADD/SUB/IMPL alone
      set_req(0, ADD, 8'hFF, 8'h01);
      bus.req_valid = 4'b0001;
      #1 chk("t4_ready_add", 32'(bus.req_ready), 1);
      @(negedge clk);
      set_req(0, SUB, 8'h00, 8'h01);
      #1 chk("t4_ready_sub", 32'(bus.req_ready), 1);
      @(negedge clk);
      set_req(0, IMPL, 8'hF0, 8'h30);
      #1 chk("t4_ready_impl", 32'(bus.req_ready), 1);
      chk("t4_add_valid", 32'(bus.rsp_valid), 1);
      chk("t4_add_data", 32'(bus.rsp_data), 32'h00);
      @(negedge clk);
      bus.req_valid = '0;
      #1 chk("t4_sub_data", 32'(bus.rsp_data), 32'hFF);
      chk("t4_sub_valid", 32'(bus.rsp_valid), 1);
      @(negedge clk);
      chk("t4_impl_data", 32'(bus.rsp_data), 32'h3F);
      chk("t4_impl_id", 32'(bus.rsp_id), 0);
      @(negedge clk);
      chk("t4_drained", 32'(bus.rsp_valid), 0);
      chk("t4_done_cnt", 32'(done_cnt), 14);

      // ---- test 5: reset with full pipe
      bus.rsp_ready = 1'b0;
      set_req(0, PASS, 8'h77, 8'h00);
      bus.req_valid = 4'b0001;
      @(negedge clk);
      @(negedge clk);
      #1 chk("t5_full_ready", 32'(bus.req_ready), 0);
      chk("t5_full_busy", 32'(busy), 1);
      chk("t5_full_rsp", 32'(bus.rsp_valid), 1);
      bus.req_valid = '0;
      #1 rst_n = 1'b0;
      #1 chk("t5_rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_done", 32'(done_cnt), 0);
      chk("t5_rst_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t5_no_stale_a", 32'(bus.rsp_valid), 0);
      @(negedge clk);
      chk("t5_no_stale_b", 32'(bus.rsp_valid), 0);
      chk("t5_idle", 32'(busy), 0);
      bus.req_valid = 4'b1111;
      #1 chk("t5_req0_first", 32'(bus.req_ready), 1);
      @(negedge clk);
      bus.req_valid = '0;

      // ---- test 6: done_cnt wrap (CNT_W=4) after 19 responses
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk("t6_rst_done", 32'(done_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      set_req(0, PASS, 8'h11, 8'h00);
      bus.req_valid = 4'b0001;
      for (int c = 0; c < 19; c++) @(negedge clk);
      bus.req_valid = '0;
      for (int c = 0; c < 3; c++) @(negedge clk);
      chk("t6_wrap_done", 32'(done_cnt), 3);
      chk("t6_idle", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
